// File: rtl/cmp_share_pkg.sv
// cmp_share_pkg: shared types, operand width and round-robin pick helper for cmp_share_ctrl
package cmp_share_pkg;
   localparam int OPW = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, RESP = 2'd2} state_t;
   function automatic logic [2:0] rr_pick(input logic [7:0] v, input logic [2:0] p, input int n);
      logic [2:0] w;
      logic f;
      w = '0;
      f = 1'b0;
      for (int i = 0; i < 8; i++) begin
         int k;
         k = (int'(p) + i) % n;
         if (i < n && !f && v[k]) begin
            w = 3'(k);
            f = 1'b1;
         end
      end
      return w;
   endfunction
endpackage

// File: rtl/cmp_share_ctrl_rr_arbiter.sv
// rr_arbiter: first valid requester at or after the pointer, wrapping, as one-hot and index
module rr_arbiter
   import cmp_share_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [ID_W-1:0]  ptr,
   input  logic             en,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  idx
);
   // Winner index is always computed; the one-hot grant is gated by enable and any-valid
   always_comb begin
      idx   = ID_W'(rr_pick(8'(valid), 3'(ptr), N_REQ));
      grant = (en && |valid) ? N_REQ'(1) << idx : '0;
   end
endmodule

// File: rtl/comparator.sv
// comparator: unsigned magnitude compare, A = x>y, B = x<y, S = x==y
module comparator
   import cmp_share_pkg::*;
(
   input  logic [OPW-1:0] x,
   input  logic [OPW-1:0] y,
   output logic           A,
   output logic           B,
   output logic           S
);
   assign A = x > y;
   assign B = x < y;
   assign S = x == y;
endmodule

// File: rtl/cmp_share_ctrl.sv
// cmp_share_ctrl: time-shares one 4-bit comparator among N_REQ round-robin requesters
module cmp_share_ctrl
   import cmp_share_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [OPW*N_REQ-1:0] req_a,
   input  logic [OPW*N_REQ-1:0] req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic                 rsp_gt,
   output logic                 rsp_lt,
   output logic                 rsp_eq,
   output logic                 busy
);
   state_t state, nxt;
   logic [ID_W-1:0] ptr, id_q, win;
   logic [OPW-1:0] a_q, b_q;
   logic c_gt, c_lt, c_eq;
   rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
      .valid(req_valid),
      .ptr  (ptr),
      .en   (state == IDLE && rst_n),
      .grant(req_ready),
      .idx  (win)
   );
   comparator u_cmp (.x(a_q), .y(b_q), .A(c_gt), .B(c_lt), .S(c_eq));
   // Accept in IDLE, spend one cycle comparing, then hold the response until it is taken
   always_comb begin
      nxt  = state;
      busy = state != IDLE;
      nxt  = (state == IDLE) ? (|req_valid ? CMP : IDLE) :
             (state == CMP)  ? RESP : (rsp_ready ? IDLE : RESP);
   end
   // State, operand capture, pointer advance and registered response
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         id_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_gt    <= 1'b0;
         rsp_lt    <= 1'b0;
         rsp_eq    <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && |req_valid) begin
            a_q  <= req_a[win*OPW +: OPW];
            b_q  <= req_b[win*OPW +: OPW];
            id_q <= win;
            ptr  <= (int'(win) == N_REQ - 1) ? '0 : win + ID_W'(1);
         end
         if (state == CMP) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_gt    <= c_gt;
            rsp_lt    <= c_lt;
            rsp_eq    <= c_eq;
         end
         if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_cmp_share_ctrl.sv
// tb_cmp_share_ctrl: directed stimulus against a transaction-level model of the shared comparator
module tb_cmp_share_ctrl;
   localparam int N = 4;
   logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b0;
   logic [N-1:0] req_valid = '0, req_ready;
   logic [4*N-1:0] req_a = '0, req_b = '0;
   logic rsp_valid, rsp_gt, rsp_lt, rsp_eq, busy;
   logic [1:0] rsp_id;
   int checks = 0, failures = 0, cyc = 0, n0 = 0;
   bit chk_en = 1'b0;
   int m_age = 0, m_ptr = 0, m_id = 0, m_a = 0, m_b = 0, m_rid = 0;
   bit m_rv = 1'b0, m_gt = 1'b0, m_lt = 1'b0, m_eq = 1'b0;
   int g_id[$], g_cyc[$], r_id[$], m_g[$];
   logic [2:0] r_fl[$];
   int exp_seq[6] = '{0, 1, 2, 3, 0, 1};

   always #5 clk = ~clk;

   cmp_share_ctrl #(.N_REQ(N), .ID_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_gt(rsp_gt), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .busy(busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   function automatic int oh_idx(input logic [N-1:0] g);
      for (int i = 0; i < N; i++) if (g[i]) return i;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input int a, input int b);
      req_a[4*i +: 4] = 4'(a);
      req_b[4*i +: 4] = 4'(b);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      tick();
      tick();
      rst_n = 1'b1;
      g_id.delete(); g_cyc.delete(); r_id.delete(); r_fl.delete(); m_g.delete();
   endtask

   // Transaction model: one service = accept, compare, hold response until taken
   always @(posedge clk) begin
      int w;
      cyc++;
      if (rst_n && |req_ready) begin
         g_id.push_back(oh_idx(req_ready));
         g_cyc.push_back(cyc);
      end
      if (rst_n && rsp_valid && rsp_ready) begin
         r_id.push_back(int'(rsp_id));
         r_fl.push_back({rsp_gt, rsp_lt, rsp_eq});
      end
      if (!rst_n) begin
         m_age = 0; m_ptr = 0; m_rv = 0; m_rid = 0;
      end else if (m_age == 0) begin
         w = pick(req_valid, m_ptr);
         if (w >= 0) begin
            m_id = w;
            m_a = int'(req_a[4*w +: 4]);
            m_b = int'(req_b[4*w +: 4]);
            m_ptr = (w + 1) % N;
            m_age = 1;
            m_g.push_back(w);
         end
      end else if (m_age == 1) begin
         m_rv = 1; m_rid = m_id;
         m_gt = m_a > m_b; m_lt = m_a < m_b; m_eq = m_a == m_b;
         m_age = 2;
      end else if (rsp_ready) begin
         m_rv = 0; m_age = 0;
      end
   end

   // Every-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      int w;
      logic [N-1:0] er;
      if (chk_en) begin
         w = pick(req_valid, m_ptr);
         er = (rst_n && m_age == 0 && w >= 0) ? 4'(1) << w : '0;
         chk("req_ready", 32'(req_ready), 32'(er));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
         chk("busy", 32'(busy), 32'(m_age != 0));
         if (m_rv) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_rid));
            chk("rsp_gt", 32'(rsp_gt), 32'(m_gt));
            chk("rsp_lt", 32'(rsp_lt), 32'(m_lt));
            chk("rsp_eq", 32'(rsp_eq), 32'(m_eq));
            chk("one_flag", 32'(int'(rsp_gt) + int'(rsp_lt) + int'(rsp_eq)), 1);
         end
      end
   end

   initial begin
      #60000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tick();
      chk_en = 1'b1;
      tick();
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 0);
      tick();
      rst_n = 1'b1;
      // single request from requester 0: 0xF vs 0x0
      set_op(0, 15, 0); req_valid = 4'b0001; rsp_ready = 1'b1;
      @(negedge clk); chk("t1_ready", 32'(req_ready), 32'b0001);
      tick(); req_valid = '0;
      @(negedge clk); chk("t1_busy_cmp", 32'(busy), 1);
      tick();
      @(negedge clk);
      chk("t1_valid", 32'(rsp_valid), 1); chk("t1_id", 32'(rsp_id), 0);
      chk("t1_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'(3'b100));
      tick();
      @(negedge clk); chk("t1_idle", 32'(busy), 0);
      // requester 2: equal then less-than
      set_op(2, 7, 7); req_valid = 4'b0100;
      tick(); req_valid = '0; tick();
      @(negedge clk);
      chk("t2a_id", 32'(rsp_id), 2); chk("t2a_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'(3'b001));
      tick();
      set_op(2, 0, 1); req_valid = 4'b0100;
      tick(); req_valid = '0; tick();
      @(negedge clk);
      chk("t2b_id", 32'(rsp_id), 2); chk("t2b_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'(3'b010));
      tick();
      // all four continuously valid from reset
      do_reset();
      for (int i = 0; i < N; i++) set_op(i, 3 * i, 5);
      req_valid = 4'b1111; rsp_ready = 1'b1;
      repeat (17) tick();
      req_valid = '0;
      repeat (3) tick();
      chk("t3_grants", 32'(g_id.size()), 6);
      for (int i = 0; i < 6; i++) begin
         chk("t3_grant_seq", 32'(g_id[i]), 32'(exp_seq[i]));
         chk("t3_model_seq", 32'(m_g[i]), 32'(exp_seq[i]));
         chk("t3_rsp_id", 32'(r_id[i]), 32'(exp_seq[i]));
         if (i > 0) chk("t3_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 3);
      end
      // backpressure with requesters 1 and 2 pending
      do_reset();
      set_op(1, 3, 9); set_op(2, 5, 2);
      rsp_ready = 1'b0; req_valid = 4'b0110;
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", 32'(rsp_valid), 1); chk("t4_hold_id", 32'(rsp_id), 1);
         chk("t4_hold_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'(3'b010));
         chk("t4_hold_ready", 32'(req_ready), 0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      @(negedge clk); chk("t4_next_ready", 32'(req_ready), 32'b0100);
      tick(); req_valid = '0;
      tick(); tick();
      chk("t4_next_grant", 32'(g_id[g_id.size()-1]), 2);
      // reset during the compare cycle
      set_op(0, 1, 2); req_valid = 4'b0001;
      tick();
      rst_n = 1'b0; req_valid = 4'b1111; set_op(0, 9, 4);
      tick();
      @(negedge clk);
      chk("t5_valid", 32'(rsp_valid), 0); chk("t5_busy", 32'(busy), 0);
      n0 = r_id.size();
      tick(); rst_n = 1'b1;
      @(negedge clk); chk("t5_first_grant", 32'(req_ready), 32'b0001);
      tick(); req_valid = '0;
      repeat (3) tick();
      chk("t5_rsp_count", 32'(r_id.size() - n0), 1);
      chk("t5_rsp_id", 32'(r_id[r_id.size()-1]), 0);
      chk("t5_rsp_flags", 32'(r_fl[r_fl.size()-1]), 32'(3'b100));
      // exhaustive sweep through requester 3
      n0 = r_id.size();
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++) begin
            set_op(3, a, b); req_valid = 4'b1000;
            tick(); req_valid = '0;
            tick(); tick();
         end
      tick();
      chk("t6_rsp_count", 32'(r_id.size() - n0), 256);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
